// File: rtl/ama_riscv_id_pipe_if.sv
// IF->ID boundary bundle: fetch-side inputs, hazard controls and the
// registered ID-stage outputs feeding the immediate generator.
interface ama_riscv_id_pipe_if;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        valid_id;
  logic [3:0]  ig_sel;
  logic [24:0] ig_in;
  logic        ig_en;
  logic        illegal_id;

  modport master (
    output inst_in, pc_in, stall_in, flush_in,
    input  inst_id, pc_id, valid_id,
    input  ig_sel, ig_in, ig_en, illegal_id
  );

  modport slave (
    input  inst_in, pc_in, stall_in, flush_in,
    output inst_id, pc_id, valid_id,
    output ig_sel, ig_in, ig_en, illegal_id
  );
endinterface

// File: rtl/ama_riscv_id_pipe.sv
// IF/ID register with registered immediate-select decode and warm-up.
// Optional: define AMA_RISCV_ID_ILLEGAL_EN for illegal-opcode detection.
package ama_riscv_id_pkg;
  localparam logic [3:0] IG_DISABLED = 4'd0;
  localparam logic [3:0] IG_I_TYPE   = 4'd1;
  localparam logic [3:0] IG_S_TYPE   = 4'd2;
  localparam logic [3:0] IG_B_TYPE   = 4'd3;
  localparam logic [3:0] IG_J_TYPE   = 4'd4;
  localparam logic [3:0] IG_U_TYPE   = 4'd5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic [3:0]  ig_sel;
    logic        ig_en;
  } if_id_t;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_WARM,
    ST_RUN
  } id_state_e;

  function automatic logic [3:0] ig_decode(
    input logic [6:0] op
  );
    logic [3:0] r;
    unique case (op)
      7'b0110111,
      7'b0010111: r = IG_U_TYPE;
      7'b1101111: r = IG_J_TYPE;
      7'b1100111,
      7'b0000011,
      7'b0010011: r = IG_I_TYPE;
      7'b0100011: r = IG_S_TYPE;
      7'b1100011: r = IG_B_TYPE;
      default:    r = IG_DISABLED;
    endcase
    return r;
  endfunction
endpackage

module ama_riscv_id_pipe
  import ama_riscv_id_pkg::*;
#(
  parameter int unsigned WARMUP_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  ama_riscv_id_pipe_if.slave  id
);

  localparam logic [3:0] WARM_LAST = 4'(WARMUP_CYC - 1);

  localparam if_id_t ID_RST = '{
    inst:   NOP,
    pc:     32'h0,
    valid:  1'b0,
    ig_sel: IG_I_TYPE,
    ig_en:  1'b1
  };

  id_state_e   state;
  id_state_e   state_nxt;
  logic [3:0]  warm_cnt;
  logic [3:0]  warm_cnt_nxt;
  if_id_t      id_q;
  if_id_t      id_d;
  logic        ld_bub;
  logic        ld_inst;
  logic [31:0] ld_val;
  logic [3:0]  ld_sel;

  // Next-state and load-select: warm-up bubbles, then flush > stall > load
  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    ld_bub       = 1'b0;
    ld_inst      = 1'b0;
    unique case (state)
      ST_RESET: begin
        ld_bub = 1'b1;
        if (WARMUP_CYC <= 1) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt    = ST_WARM;
          warm_cnt_nxt = 4'd1;
        end
      end
      ST_WARM: begin
        ld_bub = 1'b1;
        if (warm_cnt == WARM_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          warm_cnt_nxt = warm_cnt + 4'd1;
        end
      end
      ST_RUN: begin
        if (id.flush_in) begin
          ld_bub = 1'b1;
        end else if (!id.stall_in) begin
          ld_inst = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

  // Decode the value being loaded so it registers alongside it
  always_comb begin
    ld_val = ld_bub ? NOP : id.inst_in;
    ld_sel = ig_decode(ld_val[6:0]);
    id_d   = id_q;
    if (ld_bub || ld_inst) begin
      id_d.inst   = ld_val;
      id_d.pc     = id.pc_in;
      id_d.valid  = ld_inst;
      id_d.ig_sel = ld_sel;
      id_d.ig_en  = (ld_sel != IG_DISABLED);
    end
  end

  // FSM, warm-up counter and ID pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      warm_cnt <= 4'd0;
      id_q     <= ID_RST;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
      id_q     <= id_d;
    end
  end

`ifdef AMA_RISCV_ID_ILLEGAL_EN
  logic ill_q;
  logic ld_legal;

  // Opcodes with a defined meaning; OP and SYSTEM carry no immediate
  always_comb begin
    ld_legal = (ld_sel != IG_DISABLED) ||
               (ld_val[6:0] == 7'b0110011) ||
               (ld_val[6:0] == 7'b1110011);
  end

  // Illegal flag is only raised for real (valid) loads
  always_ff @(posedge clk) begin
    if (rst) begin
      ill_q <= 1'b0;
    end else if (ld_bub) begin
      ill_q <= 1'b0;
    end else if (ld_inst) begin
      ill_q <= !ld_legal;
    end
  end

  assign id.illegal_id = ill_q;
`else
  assign id.illegal_id = 1'b0;
`endif

  assign id.inst_id  = id_q.inst;
  assign id.pc_id    = id_q.pc;
  assign id.valid_id = id_q.valid;
  assign id.ig_sel   = id_q.ig_sel;
  assign id.ig_in    = id_q.inst[31:7];
  assign id.ig_en    = id_q.ig_en;

endmodule

// File: doc/ama_riscv_id_pipe.md
# ama_riscv_id_pipe

IF/ID pipeline register and immediate-select decoder for the AMA-RISCV core. It captures the fetched instruction and PC each cycle and decodes the opcode into the immediate-generator controls (`ig_sel`, `ig_in`, `ig_en`), all registered together. The immediate generator consumes these outputs directly in the ID stage. After reset it runs a warm-up sequence of NOP bubbles, and it supports stall (hold) and flush (bubble insertion) from hazard control.

## Interface
- `WARMUP_CYC`, default 2: NOP bubble cycles issued after reset deassertion, covering imem read latency; legal range 1..15.
- `clk` in 1: single core clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `inst_in` in 32: instruction from the imem read port.
- `pc_in` in 32: PC of `inst_in`.
- `stall_in` in 1: hold all ID registers.
- `flush_in` in 1: replace the next captured instruction with a NOP bubble.
- `inst_id` out 32: registered instruction.
- `pc_id` out 32: registered PC.
- `valid_id` out 1: 1 when `inst_id` is a real instruction, 0 when it is a bubble.
- `ig_sel` out 4: immediate type, using the `IG_*` encodings from `ama_riscv_defines.v`.
- `ig_in` out 25: equal to `inst_id[31:7]`.
- `ig_en` out 1: 1 when `ig_sel != IG_DISABLED`.
- `illegal_id` out 1: `inst_id` has an unsupported opcode (see Configuration).

## Operation
- NOP is defined as `32'h0000_0013` (`addi x0,x0,0`). Its decode is `ig_sel=IG_I_TYPE`, `ig_en=1`.
- Opcode `inst[6:0]` decodes to `ig_sel` as follows:
  - `0110111` LUI and `0010111` AUIPC: `IG_U_TYPE`.
  - `1101111` JAL: `IG_J_TYPE`.
  - `1100111` JALR, `0000011` LOAD, `0010011` OP-IMM: `IG_I_TYPE`.
  - `0100011` STORE: `IG_S_TYPE`.
  - `1100011` BRANCH: `IG_B_TYPE`.
  - `0110011` OP and `1110011` SYSTEM: `IG_DISABLED`.
  - Any other opcode: `IG_DISABLED`, and the instruction is illegal.
- Decode is computed from the value being loaded and registered with it. Registered `ig_sel`/`ig_en`/`illegal_id` therefore always match `inst_id`.
- FSM states:
  - RESET: while `rst=1`. The next state is WARM.
  - WARM: a counter `warm_cnt` runs from 0 to `WARMUP_CYC-1`, incrementing every cycle; it is not affected by stall or flush. ID loads a NOP with `valid_id=0`. After the last count the FSM moves to RUN.
  - RUN: normal operation.
- Per-cycle priority in RUN: `rst` > `flush_in` > `stall_in` > load.
  - Flush: load NOP, `pc_id` loads `pc_in`, `valid_id=0`.
  - Stall: all outputs hold.
  - Load: capture `inst_in`/`pc_in` with `valid_id=1`.
- `flush_in` and `stall_in` both high: flush wins, and a bubble is loaded.
- `rst` asserted mid-operation, including mid-WARM or mid-stall: the next edge applies reset values and the warm-up sequence restarts from count 0.
- Reset values:
  - `inst_id=32'h0000_0013`, `pc_id=0`, `valid_id=0`.
  - `ig_sel=IG_I_TYPE`, `ig_in=25'h0`, `ig_en=1`, `illegal_id=0`.
  - FSM=RESET, `warm_cnt=0`.
- A bubble never asserts `illegal_id`.

## Timing
- Latency is 1 cycle: `inst_in` sampled at edge N appears on `inst_id`/`ig_*` after edge N.
- All outputs are registered; there is no combinational path from any input to any output.
- With `rst` released before edge R:
  - Edges R..R+`WARMUP_CYC`-1 load bubbles.
  - Edge R+`WARMUP_CYC` is the first edge that can capture `inst_in` with `valid_id=1`.
- A stall of k cycles holds outputs for exactly k cycles; the input present on the edge after stall deassertion is captured.
- A flush pulse of 1 cycle produces exactly 1 bubble.

## Configuration
- `AMA_RISCV_ID_ILLEGAL_EN` defined:
  - Illegal-opcode detection is compiled in.
  - `illegal_id` is registered and set for unmapped opcodes on valid loads.
  - An illegal instruction still loads with `valid_id=1`, and its `ig_sel` is `IG_DISABLED`.
- `AMA_RISCV_ID_ILLEGAL_EN` undefined:
  - `illegal_id` is tied to 0 and there is no detection logic.
  - Unmapped opcodes still decode to `IG_DISABLED`.

## Test plan
- Reset then warm-up: hold `rst=1` for 3 cycles, release, drive `inst_in=32'h0010_0093` (addi x1,x0,1).
  - Required: `valid_id=0` and `inst_id=32'h0000_0013` for 2 cycles.
  - Then `inst_id=32'h0010_0093`, `ig_sel=IG_I_TYPE`, `ig_in=25'h0002001`, `valid_id=1`.
- Decode sweep in RUN: apply one instruction per cycle and check `ig_sel` one cycle later.
  - `32'h0000_00B7` (lui) gives U.
  - `32'h0000_006F` (jal) gives J.
  - `32'h0020_A023` (sw) gives S.
  - `32'h0000_0463` (beq) gives B.
  - `32'h0020_81B3` (add) gives `IG_DISABLED` with `ig_en=0`.
- Stall: assert `stall_in` for 3 cycles while `inst_in` changes.
  - Required: `inst_id`/`pc_id` hold their pre-stall values for 3 cycles.
  - On the following cycle, the then-current `inst_in` is captured.
- Flush vs stall: assert `flush_in=1` and `stall_in=1` together for 1 cycle.
  - Required: next cycle `inst_id=32'h0000_0013`, `valid_id=0`, `pc_id=pc_in`.
- Mid-warm reset: release `rst`, then reassert it for 1 cycle after 1 warm cycle.
  - Required: warm-up restarts and the first `valid_id=1` appears 2 cycles after the second release.
- Illegal opcode (`AMA_RISCV_ID_ILLEGAL_EN` defined): load `32'hFFFF_FFFF`.
  - Required: `illegal_id=1`, `ig_sel=IG_DISABLED`, `valid_id=1`.
  - A following flush clears `illegal_id` to 0.
